// File: rtl/neuron_pkg.sv
// neuron_pkg: shared definitions for the neuron load/compute sequencer.
//   - sel_e    : command codes carried on sel
//   - state_e  : compute FSM states
//   - widths   : byte, product and accumulator widths; load lengths
//   - relu_sat : clamp a signed accumulator to an unsigned 8-bit output
package neuron_pkg;

  localparam int W_BYTE    = 8;
  localparam int PROD_W    = 17;  // signed 8b x unsigned 8b
  localparam int ACC_W     = 19;  // four products without overflow
  localparam int W_NIBBLES = 8;   // 4 weight bytes
  localparam int D_NIBBLES = 32;  // 16 data bytes

  typedef enum logic [1:0] {
    SEL_CLR   = 2'b00,
    SEL_LDW   = 2'b01,
    SEL_LDD   = 2'b10,
    SEL_START = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    EMIT
  } state_e;

  // Negative -> 0, anything above 255 -> 255, else the low byte.
  function automatic logic [W_BYTE-1:0] relu_sat(input logic signed [ACC_W-1:0] a);
    if (a[ACC_W-1])
      return '0;
    else if (|a[ACC_W-2:W_BYTE])
      return '1;
    else
      return a[W_BYTE-1:0];
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// neuron_mac: signed-weight x unsigned-sample multiply-accumulate.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the accumulator (wins over en)
//   en       : add w*x into the accumulator this cycle
//   w        : signed 8-bit weight
//   x        : unsigned 8-bit sample
//   sum_sat  : ReLU/saturated value of (acc + w*x), i.e. what the
//              accumulator holds after this cycle's add
module neuron_mac
  import neuron_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [W_BYTE-1:0] w,
  input  logic [W_BYTE-1:0] x,
  output logic [W_BYTE-1:0] sum_sat
);

  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;

  // Weight is sign-extended, sample zero-extended, so the multiply is
  // effectively signed x unsigned in a signed 17-bit container.
  assign w_ext   = {{(PROD_W-W_BYTE){w[W_BYTE-1]}}, w};
  assign x_ext   = {{(PROD_W-W_BYTE){1'b0}}, x};
  assign prod    = w_ext * x_ext;
  assign sum     = acc + ACC_W'(prod);
  assign sum_sat = relu_sat(sum);

  // NOTE: clocked state is always written with <= so every register
  // samples the pre-edge values of its neighbours, regardless of order.
  always_ff @(posedge clk) begin
    if (rst || clr)
      acc <= '0;
    else if (en)
      acc <= sum;
  end

endmodule

// File: rtl/neuron_seq.sv
// neuron_seq: nibble loader and MAC scheduler for the tiny neuron.
//   clk, rst      : clock, synchronous active-high reset
//   nib_in        : 4-bit load payload
//   sel           : 00 clear, 01 load weight nibble, 10 load data nibble, 11 start
//   cmd_valid     : qualifies sel/nib_in for one cycle
//   weights       : 4 x signed byte, first nibble loaded lands in [31:28]
//   data          : 16 x unsigned byte, first nibble loaded lands in [127:124]
//   w_full/d_full : load of the respective register is complete
//   busy          : compute in progress
//   result        : last neuron output (held between strobes)
//   result_valid  : one-cycle strobe per result
//   result_last   : accompanies the fourth strobe
//   err           : sticky command error, cleared only by clear or reset
module neuron_seq
  import neuron_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                nib_in,
  input  logic [1:0]                sel,
  input  logic                      cmd_valid,
  output logic [4*W_BYTE-1:0]       weights,
  output logic [16*W_BYTE-1:0]      data,
  output logic                      w_full,
  output logic                      d_full,
  output logic                      busy,
  output logic [W_BYTE-1:0]         result,
  output logic                      result_valid,
  output logic                      result_last,
  output logic                      err
);

  localparam int WC_W = $clog2(W_NIBBLES + 1);
  localparam int DC_W = $clog2(D_NIBBLES + 1);

  sel_e            cmd;
  state_e          state, state_nxt;
  logic [WC_W-1:0] w_cnt;
  logic [DC_W-1:0] d_cnt;
  logic [1:0]      s_idx;   // sample 0..3
  logic [1:0]      k_idx;   // tap 0..3
  logic            start_ok;
  logic            mac_clr;
  logic            mac_en;
  logic [4:0]      w_off;
  logic [6:0]      d_off;
  logic [W_BYTE-1:0] w_byte;
  logic [W_BYTE-1:0] x_byte;
  logic [W_BYTE-1:0] sum_sat;

  assign cmd      = sel_e'(sel);
  assign w_full   = (w_cnt == WC_W'(W_NIBBLES));
  assign d_full   = (d_cnt == DC_W'(D_NIBBLES));
  assign busy     = (state != IDLE);
  assign start_ok = cmd_valid && (state == IDLE) && (cmd == SEL_START) && w_full && d_full;

  // Byte 0 sits in the top bits, so the bit offset is (last_index - i) * 8;
  // inverting the index gives last_index - i without a subtractor.
  assign w_off  = {~k_idx, 3'b000};
  assign d_off  = {~{s_idx, k_idx}, 3'b000};
  assign w_byte = weights[w_off +: W_BYTE];
  assign x_byte = data[d_off +: W_BYTE];

  assign mac_clr = start_ok || (state == EMIT);
  assign mac_en  = (state == MAC);

  neuron_mac u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .w       (w_byte),
    .x       (x_byte),
    .sum_sat (sum_sat)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // NOTE: the default assignment first means every path assigns
  // state_nxt, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_ok) state_nxt = MAC;
      MAC:  if (k_idx == 2'd3) state_nxt = EMIT;
      EMIT: state_nxt = (s_idx == 2'd3) ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  // Load/clear handling and command error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      weights <= '0;
      data    <= '0;
      w_cnt   <= '0;
      d_cnt   <= '0;
      err     <= 1'b0;
    end else if (cmd_valid) begin
      if (state != IDLE) begin
        err <= 1'b1;
      end else begin
        unique case (cmd)
          SEL_CLR: begin
            weights <= '0;
            data    <= '0;
            w_cnt   <= '0;
            d_cnt   <= '0;
            err     <= 1'b0;
          end
          SEL_LDW: begin
            if (w_full) begin
              err <= 1'b1;
            end else begin
              weights <= {weights[4*W_BYTE-5:0], nib_in};
              w_cnt   <= w_cnt + 1'b1;
            end
          end
          SEL_LDD: begin
            if (d_full) begin
              err <= 1'b1;
            end else begin
              data  <= {data[16*W_BYTE-5:0], nib_in};
              d_cnt <= d_cnt + 1'b1;
            end
          end
          SEL_START: begin
            if (!(w_full && d_full)) err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Sample/tap indices and result register. The result is captured on
  // the edge that ends the fourth MAC cycle, so it and its strobe are
  // visible during the EMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_idx        <= '0;
      k_idx        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      result_last  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      result_last  <= 1'b0;
      if (start_ok) begin
        s_idx <= '0;
        k_idx <= '0;
      end else if (state == MAC) begin
        k_idx <= k_idx + 1'b1;
        if (k_idx == 2'd3) begin
          result       <= sum_sat;
          result_valid <= 1'b1;
          result_last  <= (s_idx == 2'd3);
        end
      end else if (state == EMIT) begin
        k_idx <= '0;
        s_idx <= s_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: directed and randomized checks of neuron_seq against a
// behavioural model (register images, load counts, dot products).
module tb_neuron_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   nib_in;
  logic [1:0]   sel;
  logic         cmd_valid;
  logic [31:0]  weights;
  logic [127:0] data;
  logic         w_full, d_full, busy, result_valid, result_last, err;
  logic [7:0]   result;

  neuron_seq dut (
    .clk          (clk),
    .rst          (rst),
    .nib_in       (nib_in),
    .sel          (sel),
    .cmd_valid    (cmd_valid),
    .weights      (weights),
    .data         (data),
    .w_full       (w_full),
    .d_full       (d_full),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_last  (result_last),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]  m_w;
  logic [127:0] m_d;
  int           m_wc, m_dc;
  logic         m_err;
  logic [7:0]   m_res;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Dot product of the four weights with sample s, then ReLU/saturate.
  function automatic logic [7:0] exp_result(input logic [31:0] w, input logic [127:0] d, input int s);
    int acc = 0;
    for (int k = 0; k < 4; k++) begin
      byte signed wb;
      int         xb;
      wb  = w[31-8*k -: 8];
      xb  = int'(d[127-8*(4*s+k) -: 8]);
      acc += int'(wb) * xb;
    end
    if (acc < 0)   return 8'd0;
    if (acc > 255) return 8'd255;
    return acc[7:0];
  endfunction

  task automatic model_reset();
    m_w = '0; m_d = '0; m_wc = 0; m_dc = 0; m_err = 1'b0; m_res = '0;
  endtask

  // One command, issued while the DUT is idle.
  task automatic do_cmd(input logic [1:0] s, input logic [3:0] n);
    @(negedge clk);
    sel = s; nib_in = n; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    case (s)
      2'b00: begin m_w = '0; m_d = '0; m_wc = 0; m_dc = 0; m_err = 1'b0; end
      2'b01: if (m_wc == 8) m_err = 1'b1; else begin m_w = {m_w[27:0], n}; m_wc++; end
      2'b10: if (m_dc == 32) m_err = 1'b1; else begin m_d = {m_d[123:0], n}; m_dc++; end
      default: if (!(m_wc == 8 && m_dc == 32)) m_err = 1'b1;
    endcase
  endtask

  task automatic load_w(input logic [31:0] v, input int cnt);
    for (int i = 0; i < cnt; i++) do_cmd(2'b01, v[31-4*i -: 4]);
  endtask

  task automatic load_d(input logic [127:0] v);
    for (int i = 0; i < 32; i++) do_cmd(2'b10, v[127-4*i -: 4]);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".weights"}, weights, m_w);
    check({tag, ".data"},    data,    m_d);
    check({tag, ".w_full"},  w_full,  m_wc == 8);
    check({tag, ".d_full"},  d_full,  m_dc == 32);
    check({tag, ".err"},     err,     m_err);
  endtask

  // Start a computation and check every cycle for 24 cycles. If inj_n is
  // nonzero, a command with code inj_sel is driven in cycle T+inj_n.
  task automatic compute(input string tag, input int inj_n, input logic [1:0] inj_sel);
    logic [7:0] exp_r [4];
    for (int s = 0; s < 4; s++) exp_r[s] = exp_result(m_w, m_d, s);
    @(negedge clk);
    sel = 2'b11; cmd_valid = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      logic strobe;
      @(negedge clk);
      cmd_valid = 1'b0;
      strobe = (n % 5 == 0) && (n <= 20);
      if (strobe) m_res = exp_r[n/5 - 1];
      check({tag, ".busy"},         busy,         n <= 20);
      check({tag, ".result_valid"}, result_valid, strobe);
      check({tag, ".result_last"},  result_last,  n == 20);
      check({tag, ".result"},       result,       m_res);
      if (n == inj_n) begin
        sel = inj_sel; nib_in = 4'hA; cmd_valid = 1'b1; m_err = 1'b1;
      end
    end
    check_regs(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".weights"},      weights,      '0);
    check({tag, ".data"},         data,         '0);
    check({tag, ".w_full"},       w_full,       1'b0);
    check({tag, ".d_full"},       d_full,       1'b0);
    check({tag, ".busy"},         busy,         1'b0);
    check({tag, ".result"},       result,       8'd0);
    check({tag, ".result_valid"}, result_valid, 1'b0);
    check({tag, ".result_last"},  result_last,  1'b0);
    check({tag, ".err"},          err,          1'b0);
  endtask

  task automatic fresh_load(input logic [31:0] w, input logic [127:0] d);
    do_cmd(2'b00, 4'h0);
    load_w(w, 8);
    load_d(d);
  endtask

  logic [127:0] seq_data;
  logic [127:0] rnd_d;
  logic [31:0]  rnd_w;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; sel = 2'b00; nib_in = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int j = 0; j < 16; j++) seq_data[127-8*j -: 8] = 8'(j + 1);

    // Unit weights, ramp data: 10, 26, 42, 58.
    fresh_load(32'h01010101, seq_data);
    check_regs("ramp_load");
    compute("ramp", 0, 2'b00);
    check("ramp.r3_value", m_res, 8'd58);

    // All -1 weights: ReLU clamps to 0.
    rnd_d = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1;
    fresh_load(32'hFFFFFFFF, rnd_d);
    compute("neg", 0, 2'b00);

    // Largest positive sum saturates.
    fresh_load(32'h7F7F7F7F, {16{8'hFF}});
    compute("sat_hi", 0, 2'b00);

    // Most negative sum clamps to 0.
    fresh_load(32'h80808080, {16{8'hFF}});
    compute("sat_lo", 0, 2'b00);

    // Start with only 7 weight nibbles: rejected.
    do_cmd(2'b00, 4'h0);
    check("clr.err", err, 1'b0);
    load_w(32'h12345678, 7);
    load_d(seq_data);
    do_cmd(2'b11, 4'h0);
    check_regs("short_start");
    repeat (3) begin
      @(negedge clk);
      check("short_start.busy", busy, 1'b0);
    end

    // Load while busy at T+3: ignored, err set, results unaffected.
    fresh_load(32'h01010101, seq_data);
    compute("busy_ldw", 3, 2'b01);

    // Ninth weight nibble in IDLE.
    fresh_load(32'hA5C3_0F96, seq_data);
    check("ninth.err_before", err, 1'b0);
    do_cmd(2'b01, 4'hE);
    check_regs("ninth");

    // Reissue without reload, with a clear attempted mid-compute.
    compute("busy_clr", 12, 2'b00);

    // Reset in cycle T+7.
    fresh_load(32'h01010101, seq_data);
    @(negedge clk);
    sel = 2'b11; cmd_valid = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_outputs("mid_rst");
    begin
      int strobes = 0;
      for (int n = 0; n < 25; n++) begin
        @(negedge clk);
        if (result_valid) strobes++;
      end
      check("mid_rst.no_strobe", strobes, 0);
      check("mid_rst.busy", busy, 1'b0);
    end
    load_w(32'h01010101, 8);
    load_d(seq_data);
    compute("after_rst", 0, 2'b00);

    // Randomized loads and computes; odd iterations reissue start.
    for (int it = 0; it < 8; it++) begin
      rnd_w = $urandom();
      rnd_d = {$urandom(), $urandom(), $urandom(), $urandom()};
      fresh_load(rnd_w, rnd_d);
      check_regs($sformatf("rnd%0d_load", it));
      compute($sformatf("rnd%0d", it), 0, 2'b00);
      if (it % 2 == 1) compute($sformatf("rnd%0d_again", it), 0, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
